// File: rtl/sme_pkg.sv
// Shared constants and feeder state encoding for the string-match engine front end.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    localparam logic [4:0] NO_MATCH_IDX = 5'b11111;

    // Pattern metacharacters understood by the engine.
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/sme_char_buf.sv
// Append-only character buffer with indexed read; writes are dropped once full.
module sme_char_buf #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [7:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   len,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [7:0] mem [DEPTH];

    assign full    = (len == LW'(DEPTH));
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (wr_en && !full) begin
            len <= len + LW'(1);
        end
    end

    // Storage needs no reset: only entries below len are ever read.
    always_ff @(posedge clk) begin
        if (wr_en && !clr && !full) begin
            mem[len[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sme_feeder.sv
// Buffers a string and pattern from the host, streams them to the match engine and returns its result.
// Optional WAIT watchdog enabled by defining SME_FEEDER_TIMEOUT_EN.
module sme_feeder #(
    parameter int STR_MAX     = sme_pkg::STR_MAX,
    parameter int PAT_MAX     = sme_pkg::PAT_MAX,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       clr,
    input  logic       start,
    input  logic       keep_str,
    output logic       busy,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       done,
    output logic       result_match,
    output logic [4:0] result_index,
    output logic       err
);

    import sme_pkg::*;

    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int IW  = (SAW > PAW) ? SAW : PAW;

    feeder_state_t  state, state_d;
    logic [IW-1:0]  idx, idx_d;
    logic           start_ok, err_set;

    logic           str_wr, str_clr, str_full;
    logic [7:0]     str_rd;
    logic [SLW-1:0] str_len;
    logic           pat_wr, pat_clr, pat_full;
    logic [7:0]     pat_rd;
    logic [PLW-1:0] pat_len;

    assign str_clr = (state == ST_IDLE) && clr;
    assign pat_clr = ((state == ST_IDLE) && clr) || (state == ST_DONE);
    assign str_wr  = (state == ST_IDLE) && wr_en && !clr && !wr_sel;
    assign pat_wr  = (state == ST_IDLE) && wr_en && !clr && wr_sel;

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (str_clr),
        .wr_en   (str_wr),
        .wr_data (wr_data),
        .rd_idx  (idx_d[SAW-1:0]),
        .rd_data (str_rd),
        .len     (str_len),
        .full    (str_full)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (pat_clr),
        .wr_en   (pat_wr),
        .wr_data (wr_data),
        .rd_idx  (idx_d[PAW-1:0]),
        .rd_data (pat_rd),
        .len     (pat_len),
        .full    (pat_full)
    );

`ifdef SME_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] wait_cnt;
    logic          timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end
`endif

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        start_ok = 1'b0;
        err_set  = 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (pat_len == '0 || (!keep_str && str_len == '0)) begin
                        err_set = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        idx_d    = '0;
                        state_d  = keep_str ? ST_SEND_PAT : ST_SEND_STR;
                    end
                end
            end
            ST_SEND_STR: begin
                if (int'(idx) == int'(str_len) - 1) begin
                    state_d = ST_SEND_PAT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end
            ST_SEND_PAT: begin
                if (int'(idx) == int'(pat_len) - 1) begin
                    state_d = ST_GAP;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end
            ST_GAP:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (sme_valid) begin
                    state_d = ST_DONE;
`ifdef SME_FEEDER_TIMEOUT_EN
                end else if (int'(wait_cnt) == TIMEOUT_CYC - 1) begin
                    state_d = ST_DONE;
                    timeout = 1'b1;
                    err_set = 1'b1;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Writes are refused while a transaction is in flight or the target buffer is full.
        if (wr_en) begin
            if (state != ST_IDLE) begin
                err_set = 1'b1;
            end else if (!clr && (wr_sel ? pat_full : str_full)) begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // Strobes are registered from the next state so the character and its framing leave together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
        end else begin
            isstring  <= (state_d == ST_SEND_STR);
            ispattern <= (state_d == ST_SEND_PAT);
            if (state_d == ST_SEND_STR) begin
                chardata <= str_rd;
            end else if (state_d == ST_SEND_PAT) begin
                chardata <= pat_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_match <= 1'b0;
            result_index <= NO_MATCH_IDX;
            err          <= 1'b0;
        end else begin
            if (state == ST_WAIT && sme_valid) begin
                result_match <= sme_match;
                result_index <= sme_match_index;
`ifdef SME_FEEDER_TIMEOUT_EN
            end else if (timeout) begin
                result_match <= 1'b0;
                result_index <= NO_MATCH_IDX;
`endif
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (start_ok) begin
                err <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sme_feeder.sv
// Randomized bench for sme_feeder: buffer contents and expected streams are modelled with queues.
module tb_sme_feeder;

    localparam int STR_MAX     = 32;
    localparam int PAT_MAX     = 8;
    localparam int TIMEOUT_CYC = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [7:0] wr_data = '0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       keep_str = 1'b0;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = '0;
    logic       busy, isstring, ispattern, done, result_match, err;
    logic [7:0] chardata;
    logic [4:0] result_index;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] str_q[$];
    logic [7:0] pat_q[$];
    logic       err_m = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_data         (wr_data),
        .clr             (clr),
        .start           (start),
        .keep_str        (keep_str),
        .busy            (busy),
        .chardata        (chardata),
        .isstring        (isstring),
        .ispattern       (ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index),
        .done            (done),
        .result_match    (result_match),
        .result_index    (result_index),
        .err             (err)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Every cycle: the strobes must follow the expected stream, and be low when nothing is expected.
    always @(negedge clk) begin
        logic [9:0] e;
        chk("strobe_excl", {31'b0, isstring & ispattern}, 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stream", {22'b0, isstring, ispattern, chardata}, {22'b0, e});
        end else begin
            chk("idle_strobe", {30'b0, isstring, ispattern}, 32'd0);
        end
    end

    function automatic logic [7:0] rchar();
        case ($urandom_range(0, 7))
            0: return 8'h5E;
            1: return 8'h24;
            2: return 8'h2E;
            3: return 8'h2A;
            4: return 8'h20;
            default: return 8'(97 + $urandom_range(0, 25));
        endcase
    endfunction

    function automatic void push_stream(input bit keep);
        if (!keep) foreach (str_q[k]) exp_q.push_back({2'b10, str_q[k]});
        foreach (pat_q[k]) exp_q.push_back({2'b01, pat_q[k]});
        exp_q.push_back({2'b00, pat_q[pat_q.size()-1]});
    endfunction

    task automatic wr(input bit sel, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (!sel) begin
            if (str_q.size() < STR_MAX) str_q.push_back(d); else err_m = 1'b1;
        end else begin
            if (pat_q.size() < PAT_MAX) pat_q.push_back(d); else err_m = 1'b1;
        end
        @(negedge clk);
        chk("wr_err", err, err_m);
    endtask

    task automatic clr_bufs(input bit with_wr);
        @(posedge clk); #1;
        clr = 1'b1; wr_en = with_wr; wr_sel = 1'($urandom_range(0, 1)); wr_data = rchar();
        @(posedge clk); #1;
        clr = 1'b0; wr_en = 1'b0;
        str_q.delete();
        pat_q.delete();
        @(negedge clk);
        chk("clr_err", err, err_m);
    endtask

    task automatic start_reject(input bit keep);
        @(posedge clk); #1;
        start = 1'b1; keep_str = keep;
        @(posedge clk); #1;
        start = 1'b0; keep_str = 1'b0;
        err_m = 1'b1;
        @(negedge clk);
        chk("rej_busy", busy, 1'b0);
        chk("rej_err", err, 1'b1);
        @(negedge clk);
        chk("rej_busy2", busy, 1'b0);
    endtask

    task automatic run_txn(input bit keep, input int dly, input bit m, input logic [4:0] ix,
                           input bit stray);
        int n;
        n = (keep ? 0 : str_q.size()) + pat_q.size();
        @(posedge clk); #1;
        start = 1'b1; keep_str = keep;
        @(posedge clk); #1;
        start = 1'b0; keep_str = 1'b0;
        push_stream(keep);
        err_m = 1'b0;
        for (int i = 0; i <= n + dly; i++) begin
            @(negedge clk);
            chk("busy_run", busy, 1'b1);
            chk("done_early", done, 1'b0);
            @(posedge clk); #1;
            start    = stray && (i == 0);
            keep_str = 1'($urandom_range(0, 1));
            wr_en    = stray && (i == 0);
            wr_sel   = 1'b0;
            wr_data  = 8'h7A;
            if (stray && i == 0) err_m = 1'b1;
            sme_valid = 1'b0;
            if (i == n - 1) begin
                sme_valid = 1'b1; sme_match = ~m; sme_match_index = ~ix;
            end
            if (i == n + dly) begin
                sme_valid = 1'b1; sme_match = m; sme_match_index = ix;
            end
        end
        @(posedge clk); #1;
        sme_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("res_match", result_match, m);
        chk("res_index", result_index, ix);
        chk("done_err", err, err_m);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_clear", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("stream_drained", exp_q.size(), 0);
        pat_q.delete();
    endtask

`ifdef SME_FEEDER_TIMEOUT_EN
    task automatic run_timeout();
        int n;
        n = str_q.size() + pat_q.size();
        @(posedge clk); #1;
        start = 1'b1; keep_str = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        push_stream(1'b0);
        for (int i = 0; i <= n + TIMEOUT_CYC; i++) begin
            @(negedge clk);
            chk("to_busy", busy, 1'b1);
            chk("to_early", done, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("to_done", done, 1'b1);
        chk("to_match", result_match, 1'b0);
        chk("to_index", result_index, 5'h1F);
        chk("to_err", err, 1'b1);
        @(posedge clk); #1;
        err_m = 1'b1;
        pat_q.delete();
    endtask
`endif

    initial begin
        logic [7:0] s1 [5];
        s1 = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_match", result_match, 1'b0);
        chk("rst_index", result_index, 5'h1F);
        chk("rst_char", chardata, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;

        // "ab cd" against "c": match reported at index 3.
        for (int i = 0; i < 5; i++) wr(1'b0, s1[i]);
        wr(1'b1, 8'h63);
        chk("model_len", str_q.size(), 5);
        chk("model_pin", {str_q[0], str_q[1], str_q[2], str_q[3]}, 32'h61622063);
        run_txn(1'b0, 2, 1'b1, 5'd3, 1'b0);

        // Reuse the string with pattern "^d"; stray start/write during the stream.
        wr(1'b1, 8'h5E);
        wr(1'b1, 8'h64);
        chk("model_pat", {pat_q[0], pat_q[1]}, 16'h5E64);
        run_txn(1'b1, 0, 1'b1, 5'd3, 1'b1);

        // String survives DONE: a full send repeats "ab cd".
        wr(1'b1, 8'h62);
        run_txn(1'b0, 3, 1'b1, 5'd1, 1'b0);
        start_reject(1'b0);

        // String overflow: 33rd write dropped.
        clr_bufs(1'b0);
        for (int i = 0; i < STR_MAX + 1; i++) wr(1'b0, rchar());
        chk("ovf_err", err, 1'b1);
        chk("ovf_model", str_q.size(), STR_MAX);
        wr(1'b1, 8'h2E);
        run_txn(1'b0, 1, 1'b0, 5'h1F, 1'b0);

        // Pattern overflow.
        clr_bufs(1'b0);
        wr(1'b0, 8'h78);
        for (int i = 0; i < PAT_MAX + 1; i++) wr(1'b1, rchar());
        chk("povf_err", err, 1'b1);
        run_txn(1'b0, 4, 1'b0, 5'd0, 1'b0);

        // clr beats a same-cycle write, then the empty buffers reject starts.
        clr_bufs(1'b1);
        start_reject(1'b1);
        wr(1'b1, 8'h61);
        start_reject(1'b0);
        run_txn(1'b1, 0, 1'b1, 5'd7, 1'b0);

        // Reset during the third string character.
        clr_bufs(1'b0);
        for (int i = 0; i < 5; i++) wr(1'b0, s1[i]);
        wr(1'b1, 8'h63);
        @(posedge clk); #1;
        start = 1'b1; keep_str = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        push_stream(1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        str_q.delete();
        pat_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_strobes", {30'b0, isstring, ispattern}, 32'd0);
        chk("mid_rst_index", result_index, 5'h1F);
        chk("mid_rst_done", done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        start_reject(1'b0);

        // Randomized transactions.
        for (int it = 0; it < 25; it++) begin
            int ns, np;
            bit keep;
            if ($urandom_range(0, 9) < 3) clr_bufs(1'($urandom_range(0, 1)));
            ns = $urandom_range(0, 6);
            np = ($urandom_range(0, 4) == 0) ? PAT_MAX + 1 : $urandom_range(0, 3);
            for (int i = 0; i < ns; i++) wr(1'b0, rchar());
            for (int i = 0; i < np; i++) wr(1'b1, rchar());
            keep = 1'($urandom_range(0, 1));
            if (pat_q.size() == 0 || (!keep && str_q.size() == 0)) begin
                start_reject(keep);
            end else begin
                run_txn(keep, $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
            end
        end

`ifdef SME_FEEDER_TIMEOUT_EN
        clr_bufs(1'b0);
        wr(1'b0, 8'h61);
        wr(1'b1, 8'h2A);
        run_timeout();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Initiator side of the string-match engine's character-stream interface.
- Buffers one string and one pattern written by a host, then streams them on chardata with isstring/ispattern framing.
- Waits for the engine's one-cycle valid pulse, captures match/match_index and hands the result back to the host.
- Sits between the host/testbench register port and the match engine.

Parameters:
- STR_MAX, 32, string buffer depth in characters (engine limit).
- PAT_MAX, 8, pattern buffer depth in characters (engine limit).
- TIMEOUT_CYC, 64, WAIT-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_sel  in  1  0 = append to string buffer, 1 = append to pattern buffer
- wr_data  in  8  character to append
- clr  in  1  clear both buffer lengths (IDLE only)
- start  in  1  launch one transaction
- keep_str  in  1  sampled with start: 1 = send pattern only (engine reuses previous string)
- busy  out  1  high from accepted start until the done cycle inclusive
- chardata  out  8  character to engine
- isstring  out  1  chardata is a string character
- ispattern  out  1  chardata is a pattern character
- sme_valid  in  1  engine result strobe
- sme_match  in  1  engine match flag
- sme_match_index  in  5  engine match index
- done  out  1  one-cycle result-ready pulse
- result_match  out  1  captured match
- result_index  out  5  captured index
- err  out  1  sticky error; cleared by an accepted start

Behaviour:
- Reset: all outputs 0 except result_index = 5'b11111; state IDLE; str_len = pat_len = 0.
- Reset mid-transaction returns to this state immediately; the stream is abandoned.
- FSM states: IDLE, SEND_STR, SEND_PAT, GAP, WAIT, DONE.
- Buffer writes:
  - Accepted only in IDLE. Each write appends at index len; len increments.
  - Write with len at STR_MAX/PAT_MAX: dropped, err set.
  - Write outside IDLE: dropped, err set.
  - clr in IDLE zeroes both lengths; clr has priority over wr_en in the same cycle.
- Start acceptance (IDLE only; start outside IDLE is ignored):
  - Rejected, err set, stays IDLE: pat_len == 0, or keep_str == 0 with str_len == 0.
  - Otherwise next state is SEND_STR, or SEND_PAT when keep_str = 1; busy rises the cycle after start.
- Streaming:
  - chardata/isstring/ispattern are registered; one character per cycle, index 0 first, no bubbles.
  - isstring and ispattern are never high together.
  - After the last string character, SEND_PAT starts the next cycle.
- GAP: after the last pattern character, both strobes low for exactly one cycle, then WAIT. chardata holds its last value.
- WAIT: on the first sme_valid, capture sme_match/sme_match_index into result_*, go to DONE.
- DONE: done = 1 and busy = 1 for one cycle; pat_len cleared; str_len retained for keep_str reuse; next state IDLE.
- Latency: a transaction of S string + P pattern characters has its first strobe 1 cycle after start; the GAP cycle is S+P+1 cycles after start.
- sme_valid outside WAIT is ignored and does not set err.

Optional Feature:
- Macro: SME_FEEDER_TIMEOUT_EN.
- Defined: WAIT has a counter. If sme_valid has not arrived after TIMEOUT_CYC cycles, go to DONE with result_match = 0, result_index = 5'b11111, and set err.
- Not defined: WAIT waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package sme_pkg: STR_MAX, PAT_MAX, NO_MATCH_IDX = 5'b11111, special characters (^ 8'h5E, $ 8'h24, . 8'h2E, * 8'h2A, space 8'h20), and the feeder state enum.
- One sub-module, sme_char_buf (parameterized depth, append-write, indexed read, length and full flag), instantiated twice: once for the string, once for the pattern.

Test Plan:
- Write string "ab cd", pattern "c", start with keep_str = 0:
  - isstring high 5 cycles carrying 61,62,20,63,64, then ispattern 1 cycle carrying 63, then one low cycle.
  - Model returns valid with match = 1, index = 3 → done pulse, result_match = 1, result_index = 3.
- Reuse: second start with keep_str = 1 after writing pattern "^d":
  - No isstring cycles; 2 ispattern cycles carrying 5E, 64.
  - Model returns index 3 → captured; str_len still 5.
- Overflow: 33 string writes → the 33rd is dropped, err = 1; next start streams exactly 32 characters and clears err.
- Illegal starts:
  - start with pat_len = 0 → no strobes, err = 1, busy stays 0.
  - start while busy → ignored, stream unaffected.
- Reset asserted during the 3rd string character → next cycle all strobes 0, busy = 0, result_index = 1F; a following start with pat_len = 0 is rejected.
- With SME_FEEDER_TIMEOUT_EN and no sme_valid → done arrives TIMEOUT_CYC cycles after entering WAIT, with result_match = 0, result_index = 1F, err = 1.
